// File: rtl/wf68k_bus_pkg.sv
// Shared definitions for the WF68K bus controller: FSM states, CPU size codes
// and DSACKn port-width encodings.
package wf68k_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StReq,
    StAck,
    StBerr
  } bus_state_e;

  localparam logic [1:0] SizeLong  = 2'b00;
  localparam logic [1:0] SizeByte  = 2'b01;
  localparam logic [1:0] SizeWord  = 2'b10;
  localparam logic [1:0] SizeThree = 2'b11;

  // DSACKn = {DSACK1n, DSACK0n}
  localparam logic [1:0] Dsack32   = 2'b00;
  localparam logic [1:0] Dsack16   = 2'b01;
  localparam logic [1:0] Dsack8    = 2'b10;
  localparam logic [1:0] DsackNone = 2'b11;

  function automatic logic [2:0] size_len(logic [1:0] size);
    unique case (size)
      SizeByte:  size_len = 3'd1;
      SizeWord:  size_len = 3'd2;
      SizeThree: size_len = 3'd3;
      default:   size_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/wf68k_bus_be_decode.sv
// Byte-enable decode: lanes from the address offset up to the transfer length,
// clipped at lane 3. be_o[3] is lane 0 (bits 31:24).
module wf68k_bus_be_decode
  import wf68k_bus_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] offset_i,
  output logic [3:0] be_o
);

  logic [2:0] last_lane;

  always_comb begin
    last_lane = {1'b0, offset_i} + size_len(size_i) - 3'd1;
    be_o      = 4'b0000;
    for (int unsigned lane = 0; lane < 4; lane++) begin
      be_o[3-lane] = (3'(lane) >= {1'b0, offset_i}) && (3'(lane) <= last_lane);
    end
  end

endmodule

// File: rtl/wf68k_bus_ctrl.sv
// Asynchronous 68020-style bus cycle to synchronous memory request bridge with
// wait states, address-window decode and bus-error timeout.
module wf68k_bus_ctrl
  import wf68k_bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
  parameter int unsigned MEM_AW      = 16
) (
  input  logic              CLK,
  input  logic              RESET_INn,
  input  logic [31:0]       ADR,
  input  logic              ASn,
  input  logic              DSn,
  input  logic              RWn,
  input  logic [1:0]        SIZE,
  input  logic [31:0]       CPU_WDATA,
  output logic [31:0]       CPU_RDATA,
  output logic [1:0]        DSACKn,
  output logic              BERRn,
  output logic              STERMn,
  output logic [MEM_AW-3:0] MEM_ADR,
  output logic [3:0]        MEM_BE,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [31:0]       MEM_WDATA,
  input  logic [31:0]       MEM_RDATA,
  input  logic              MEM_ACK
);

  localparam logic [32:0] WinLo    = {1'b0, MEM_BASE};
  localparam logic [32:0] WinHi    = WinLo + (33'd1 << MEM_AW);
  localparam logic [7:0]  TmoLimit = 8'(TIMEOUT);
  localparam logic [3:0]  WsLast   = 4'(WAIT_STATES - 1);

  bus_state_e state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [7:0] tmo_q, tmo_d;
  logic       start;
  logic       hit;
  logic [3:0] be_next;

  logic [MEM_AW-3:0] mem_adr_q;
  logic [3:0]        mem_be_q;
  logic              mem_we_q;
  logic [31:0]       mem_wdata_q;
  logic              mem_req_q;
  logic [31:0]       cpu_rdata_q;
  logic [1:0]        dsackn_q;
  logic              berrn_q;

  assign hit = ({1'b0, ADR} >= WinLo) && ({1'b0, ADR} < WinHi);

  wf68k_bus_be_decode u_be_decode (
    .size_i   (SIZE),
    .offset_i (ADR[1:0]),
    .be_o     (be_next)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    tmo_d   = tmo_q;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!ASn && !DSn) begin
          start  = 1'b1;
          wait_d = 4'd0;
          tmo_d  = 8'd0;
          if (!hit) begin
            state_d = StBerr;
          end else if (WAIT_STATES == 0) begin
            state_d = StReq;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (ASn) begin
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_d == TmoLimit) begin
            state_d = StBerr;
          end else if (wait_q == WsLast) begin
            state_d = StReq;
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end
      end
      StReq: begin
        if (ASn) begin
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 8'd1;
          // A same-edge acknowledge takes priority over timeout expiry.
          if (MEM_ACK) begin
            state_d = StAck;
          end else if (tmo_d == TmoLimit) begin
            state_d = StBerr;
          end
        end
      end
      StAck, StBerr: begin
        if (ASn) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_INn) begin
      state_q     <= StIdle;
      wait_q      <= 4'd0;
      tmo_q       <= 8'd0;
      mem_adr_q   <= '0;
      mem_be_q    <= 4'b0000;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 32'd0;
      mem_req_q   <= 1'b0;
      cpu_rdata_q <= 32'd0;
      dsackn_q    <= DsackNone;
      berrn_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
      if (start) begin
        mem_adr_q   <= ADR[MEM_AW-1:2];
        mem_be_q    <= be_next;
        mem_we_q    <= !RWn;
        mem_wdata_q <= CPU_WDATA;
      end
      if (state_q == StReq && state_d == StAck && !mem_we_q) begin
        cpu_rdata_q <= MEM_RDATA;
      end
      // Strobes follow the next state so every output leaves a flop.
      mem_req_q <= (state_d == StReq);
      dsackn_q  <= (state_d == StAck) ? Dsack32 : DsackNone;
      berrn_q   <= (state_d != StBerr);
    end
  end

  assign CPU_RDATA = cpu_rdata_q;
  assign DSACKn    = dsackn_q;
  assign BERRn     = berrn_q;
  assign STERMn    = 1'b1;
  assign MEM_ADR   = mem_adr_q;
  assign MEM_BE    = mem_be_q;
  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_WDATA = mem_wdata_q;

endmodule
